// File: rtl/dp_tipo_r_pipe_pkg.sv
// Shared definitions for the pipelined R-type datapath: funct codes,
// ALU operation enum and instruction field slice/decode helpers.
package dp_tipo_r_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_NOP  = 6'h00;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    NOR = 3'd4,
    SLT = 3'd5,
    NOP = 3'd6
  } alu_op_e;

  function automatic logic [5:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[31:26];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [INSTR_W-1:0] w);
    return w[25:21];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [INSTR_W-1:0] w);
    return w[20:16];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [INSTR_W-1:0] w);
    return w[15:11];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [INSTR_W-1:0] w);
    return w[5:0];
  endfunction

  // Anything that is not a supported R-type op (including the NOP) decodes to NOP.
  function automatic alu_op_e decode_op(input logic [INSTR_W-1:0] w);
    alu_op_e op_v;
    if (instr_op(w) != OP_RTYPE) begin
      op_v = NOP;
    end else begin
      case (instr_funct(w))
        FUNCT_ADD: op_v = ADD;
        FUNCT_SUB: op_v = SUB;
        FUNCT_AND: op_v = AND;
        FUNCT_OR:  op_v = OR;
        FUNCT_NOR: op_v = NOR;
        FUNCT_SLT: op_v = SLT;
        default:   op_v = NOP;
      endcase
    end
    return op_v;
  endfunction

  // True for words that must raise err: non-R-type opcode or unknown funct.
  function automatic logic is_unsupported(input logic [INSTR_W-1:0] w);
    logic bad_v;
    if (instr_op(w) != OP_RTYPE) begin
      bad_v = 1'b1;
    end else begin
      case (instr_funct(w))
        FUNCT_NOP, FUNCT_ADD, FUNCT_SUB, FUNCT_AND,
        FUNCT_OR, FUNCT_NOR, FUNCT_SLT: bad_v = 1'b0;
        default:                        bad_v = 1'b1;
      endcase
    end
    return bad_v;
  endfunction

endpackage

// File: rtl/dp_tipo_r_pipe_if.sv
// Instruction intake handshake between fetch (master) and the datapath (slave).
interface dp_tipo_r_pipe_if;
  import dp_tipo_r_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/dp_tipo_r_pipe_alu.sv
// Combinational ALU for the R-type datapath: result, zero and signed overflow.
module dp_alu
  import dp_tipo_r_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           alu_op,
  output logic [DATA_W-1:0] y,
  output logic              zf,
  output logic              ovf
);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // Select the result; overflow only meaningful for add/sub, zero otherwise.
  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (alu_op)
      ADD: begin
        y   = sum_s;
        ovf = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      SUB: begin
        y   = diff_s;
        ovf = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
      end
      AND: y = a & b;
      OR:  y = a | b;
      NOR: y = ~(a | b);
      SLT: y[0] = ($signed(a) < $signed(b));
      NOP: y = '0;
      default: y = '0;
    endcase
  end

  assign zf = (y == '0);

endmodule

// File: rtl/dp_tipo_r_pipe.sv
// Three-stage (ID/EX/WB) MIPS R-type datapath with register file,
// EX/WB forwarding (or hazard stall), preload and debug read ports.
module dp_tipo_r_pipe
  import dp_tipo_r_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter bit FWD_EN = 1'b1,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  dp_tipo_r_pipe_if.slave   in_if,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ZF_DPTR,
  output logic              ovf,
  output logic              err
);

  logic [DATA_W-1:0] rf_r [NREG];

  // Decode of the word at the intake
  logic [REG_AW-1:0] rs_s, rt_s, rd_s;
  alu_op_e           dec_op_s;
  logic              bad_s;
  logic              hazard_s;
  logic              accept_s;
  logic [DATA_W-1:0] rs_val_s, rt_val_s;

  // ID/EX register
  logic              idex_valid_r;
  alu_op_e           idex_op_r;
  logic [DATA_W-1:0] idex_a_r, idex_b_r;
  logic [REG_AW-1:0] idex_rs_r, idex_rt_r, idex_rd_r;

  // EX stage
  logic [DATA_W-1:0] op_a_s, op_b_s, alu_y_s;
  logic              alu_zf_s, alu_ovf_s;

  // EX/WB register and sticky flags
  logic              wb_valid_r;
  logic [REG_AW-1:0] wb_addr_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              zf_r, ovf_r, err_r;

  assign rs_s     = REG_AW'(instr_rs(in_if.instr));
  assign rt_s     = REG_AW'(instr_rt(in_if.instr));
  assign rd_s     = REG_AW'(instr_rd(in_if.instr));
  assign dec_op_s = decode_op(in_if.instr);
  assign bad_s    = is_unsupported(in_if.instr);
  assign accept_s = in_if.instr_valid & in_if.instr_ready;

  // RAW hazard: a source of the incoming word is the nonzero destination of an in-flight write.
  always_comb begin
    hazard_s = 1'b0;
    if (idex_valid_r && (idex_rd_r != '0) &&
        ((idex_rd_r == rs_s) || (idex_rd_r == rt_s))) begin
      hazard_s = 1'b1;
    end else if (wb_valid_r && ((wb_addr_r == rs_s) || (wb_addr_r == rt_s))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Intake is blocked by a preload, and by a hazard only when forwarding is off.
  always_comb begin
    in_if.instr_ready = 1'b1;
    if (ld_en) begin
      in_if.instr_ready = 1'b0;
    end else if ((FWD_EN == 1'b0) && hazard_s) begin
      in_if.instr_ready = 1'b0;
    end else begin
      in_if.instr_ready = 1'b1;
    end
  end

  // Operand read with bypass of the write retiring on this same edge.
  always_comb begin
    rs_val_s = '0;
    rt_val_s = '0;
    if (rs_s == '0) begin
      rs_val_s = '0;
    end else if (wb_valid_r && (wb_addr_r == rs_s)) begin
      rs_val_s = wb_data_r;
    end else begin
      rs_val_s = rf_r[rs_s];
    end
    if (rt_s == '0) begin
      rt_val_s = '0;
    end else if (wb_valid_r && (wb_addr_r == rt_s)) begin
      rt_val_s = wb_data_r;
    end else begin
      rt_val_s = rf_r[rt_s];
    end
  end

  // ID/EX register: NOPs and unsupported words enter as bubbles; err flags the latter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_r <= 1'b0;
      idex_op_r    <= NOP;
      idex_a_r     <= '0;
      idex_b_r     <= '0;
      idex_rs_r    <= '0;
      idex_rt_r    <= '0;
      idex_rd_r    <= '0;
      err_r        <= 1'b0;
    end else begin
      err_r <= accept_s & bad_s;
      if (accept_s) begin
        idex_valid_r <= (dec_op_s != NOP);
        idex_op_r    <= dec_op_s;
        idex_a_r     <= rs_val_s;
        idex_b_r     <= rt_val_s;
        idex_rs_r    <= rs_s;
        idex_rt_r    <= rt_s;
        idex_rd_r    <= rd_s;
      end else begin
        idex_valid_r <= 1'b0;
      end
    end
  end

  // EX operands: forward the EX/WB result when it targets a source register.
  always_comb begin
    op_a_s = idex_a_r;
    op_b_s = idex_b_r;
    if (FWD_EN && wb_valid_r && (wb_addr_r == idex_rs_r)) begin
      op_a_s = wb_data_r;
    end else begin
      op_a_s = idex_a_r;
    end
    if (FWD_EN && wb_valid_r && (wb_addr_r == idex_rt_r)) begin
      op_b_s = wb_data_r;
    end else begin
      op_b_s = idex_b_r;
    end
  end

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a_s),
    .b      (op_b_s),
    .alu_op (idex_op_r),
    .y      (alu_y_s),
    .zf     (alu_zf_s),
    .ovf    (alu_ovf_s)
  );

  // EX/WB register and flags; flags only move when a real op leaves EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= '0;
      wb_data_r  <= '0;
      zf_r       <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      wb_valid_r <= idex_valid_r && (idex_rd_r != '0);
      if (idex_valid_r) begin
        wb_addr_r <= idex_rd_r;
        wb_data_r <= alu_y_s;
        zf_r      <= alu_zf_s;
        ovf_r     <= alu_ovf_s;
      end else begin
        wb_addr_r <= wb_addr_r;
        wb_data_r <= wb_data_r;
        zf_r      <= zf_r;
        ovf_r     <= ovf_r;
      end
    end
  end

  // Register file: writeback wins over a preload of the same register; $0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= '0;
      end
    end else begin
      if (wb_valid_r) begin
        rf_r[wb_addr_r] <= wb_data_r;
      end
      if (ld_en && (ld_addr != '0) && !(wb_valid_r && (wb_addr_r == ld_addr))) begin
        rf_r[ld_addr] <= ld_data;
      end
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf_r[dbg_addr];
  assign wb_valid = wb_valid_r;
  assign wb_addr  = wb_addr_r;
  assign wb_data  = wb_data_r;
  assign ZF_DPTR  = zf_r;
  assign ovf      = ovf_r;
  assign err      = err_r;

endmodule

// File: tb/tb_dp_tipo_r_pipe.sv
// Scoreboard bench for dp_tipo_r_pipe: writes predicted at issue, compared on wb_*.
module tb_dp_tipo_r_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dp_tipo_r_pipe_if in_if ();
  dp_tipo_r_pipe_if nf_if ();

  logic        ld_en, nf_ld_en;
  logic [4:0]  ld_addr, nf_ld_addr, dbg_addr, nf_dbg_addr;
  logic [31:0] ld_data, nf_ld_data, dbg_data, nf_dbg_data;
  logic        wb_valid, nf_wb_valid;
  logic [4:0]  wb_addr, nf_wb_addr;
  logic [31:0] wb_data, nf_wb_data;
  logic        zf, nf_zf, ovf, nf_ovf, err, nf_err;

  dp_tipo_r_pipe #(.DATA_W(32), .NREG(32), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_if(in_if),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ZF_DPTR(zf), .ovf(ovf), .err(err)
  );

  dp_tipo_r_pipe #(.DATA_W(32), .NREG(32), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .in_if(nf_if),
    .ld_en(nf_ld_en), .ld_addr(nf_ld_addr), .ld_data(nf_ld_data),
    .dbg_addr(nf_dbg_addr), .dbg_data(nf_dbg_data),
    .wb_valid(nf_wb_valid), .wb_addr(nf_wb_addr), .wb_data(nf_wb_data),
    .ZF_DPTR(nf_zf), .ovf(nf_ovf), .err(nf_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [36:0] sb[$];
  logic [31:0] m_rf [32];
  logic        m_zf, m_ovf;

  // Scoreboard monitor: every register write must match the oldest prediction.
  always @(negedge clk) begin
    logic [36:0] exp_v;
    if (rst_n && wb_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got addr %0d data %h, expected no write", wb_addr, wb_data);
      end else begin
        exp_v = sb.pop_front();
        if ({wb_addr, wb_data} !== exp_v) begin
          n_bad++;
          $display("FAIL wb_write: got addr %0d data %h, expected addr %0d data %h",
                   wb_addr, wb_data, exp_v[36:32], exp_v[31:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.instr_valid = 1'b0;
    in_if.instr       = 32'h0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d, input bit upd);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick(1);
    ld_en = 1'b0;
    if (upd && a != 5'd0) m_rf[a] = d;
  endtask

  // Present one word, predict its effect, return just after the accept edge.
  task automatic send(input logic [31:0] w);
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, y;
    logic [32:0] s33;
    logic        ok, ov;
    rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    a = m_rf[rs]; b = m_rf[rt];
    ok = (w[31:26] == 6'd0); ov = 1'b0; y = 32'd0;
    case (w[5:0])
      6'h20: begin s33 = {a[31], a} + {b[31], b}; y = s33[31:0]; ov = s33[32] ^ s33[31]; end
      6'h22: begin s33 = {a[31], a} - {b[31], b}; y = s33[31:0]; ov = s33[32] ^ s33[31]; end
      6'h24: y = a & b;
      6'h25: y = a | b;
      6'h27: y = ~(a | b);
      6'h2A: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: ok = 1'b0;
    endcase
    if (ok) begin
      m_zf = (y == 32'd0); m_ovf = ov;
      if (rd != 5'd0) begin m_rf[rd] = y; sb.push_back({rd, y}); end
    end
    in_if.instr_valid = 1'b1;
    in_if.instr       = w;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_vec++;
    if ({wb_valid, wb_addr, wb_data, zf, ovf, err} !== 40'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, expected 0", {wb_valid, wb_addr, wb_data, zf, ovf, err});
    end
    n_vec++;
    if (in_if.instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b, expected 1", in_if.instr_ready); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_sub_basic();
    preload(5'd15, 32'd5, 1'b1);
    preload(5'd9, 32'd3, 1'b1);
    send(32'h01E9A022);
    idle();
    tick(1);
    n_vec++;
    if (zf !== 1'b0 || wb_data !== 32'd2) begin n_bad++; $display("FAIL sub_zf: got zf %b data %h, expected 0 2", zf, wb_data); end
    tick(1);
    dbg_addr = 5'd20; #1;
    n_vec++;
    if (dbg_data !== 32'd2) begin n_bad++; $display("FAIL sub_dbg20: got %h, expected 2", dbg_data); end
  endtask

  task automatic test_back_to_back();
    send(32'h01E9A022);
    send(32'h0289A022);
    n_vec++;
    if (in_if.instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b, expected 1", in_if.instr_ready); end
    idle();
    tick(2);
    dbg_addr = 5'd20; #1;
    n_vec++;
    if (dbg_data !== 32'hFFFFFFFF || zf !== 1'b0) begin
      n_bad++; $display("FAIL b2b_result: got %h zf %b, expected ffffffff 0", dbg_data, zf);
    end
  endtask

  task automatic test_overflow();
    preload(5'd5, 32'h7FFFFFFF, 1'b1);
    preload(5'd15, 32'd1, 1'b1);
    send(32'h00AF7820);
    send(32'h01EF4022);
    idle();
    n_vec++;
    if (ovf !== 1'b1) begin n_bad++; $display("FAIL add_ovf: got %b, expected 1", ovf); end
    tick(1);
    n_vec++;
    if (zf !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL sub_self_flags: got zf %b ovf %b, expected 1 0", zf, ovf); end
    dbg_addr = 5'd15; #1;
    n_vec++;
    if (dbg_data !== 32'h80000000) begin n_bad++; $display("FAIL add_dbg15: got %h, expected 80000000", dbg_data); end
    tick(1);
    dbg_addr = 5'd8; #1;
    n_vec++;
    if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL sub_dbg8: got %h, expected 0", dbg_data); end
  endtask

  task automatic test_slt_r0();
    preload(5'd20, 32'hFFFFFFFF, 1'b1);
    preload(5'd15, 32'd2, 1'b1);
    preload(5'd0, 32'h55, 1'b1);
    send(32'h01EF0020);
    idle();
    tick(1);
    n_vec++;
    if (wb_valid !== 1'b0 || zf !== 1'b0) begin n_bad++; $display("FAIL rd0_add: got wb_valid %b zf %b, expected 0 0", wb_valid, zf); end
    send(32'h028FA82A);
    idle();
    tick(2);
    dbg_addr = 5'd21; #1;
    n_vec++;
    if (dbg_data !== 32'd1) begin n_bad++; $display("FAIL slt_dbg21: got %h, expected 1", dbg_data); end
    dbg_addr = 5'd0; #1;
    n_vec++;
    if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL r0_reads0: got %h, expected 0", dbg_data); end
  endtask

  task automatic test_nop_err();
    send(32'h01EF4022);
    idle();
    tick(2);
    send(32'h00000000);
    idle();
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL nop_err: got %b, expected 0", err); end
    tick(2);
    n_vec++;
    if (zf !== m_zf || ovf !== m_ovf) begin n_bad++; $display("FAIL nop_flags: got zf %b ovf %b, expected %b %b", zf, ovf, m_zf, m_ovf); end
    send(32'h8C000000);
    idle();
    n_vec++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL op_err_pulse: got %b, expected 1", err); end
    tick(1);
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL op_err_end: got %b, expected 0", err); end
    send(32'h01EFA83F);
    idle();
    n_vec++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL funct_err: got %b, expected 1", err); end
    tick(2);
    dbg_addr = 5'd21; #1;
    n_vec++;
    if (dbg_data !== 32'd1 || zf !== 1'b1) begin n_bad++; $display("FAIL funct_nowrite: got %h zf %b, expected 1 1", dbg_data, zf); end
  endtask

  task automatic test_ld_collide();
    send(32'h01EF4820);
    idle();
    tick(1);
    ld_en = 1'b1; ld_addr = 5'd9; ld_data = 32'hDEADBEEF; #1;
    n_vec++;
    if (in_if.instr_ready !== 1'b0) begin n_bad++; $display("FAIL ld_ready: got %b, expected 0", in_if.instr_ready); end
    tick(1);
    ld_en = 1'b0;
    dbg_addr = 5'd9; #1;
    n_vec++;
    if (dbg_data !== 32'd4) begin n_bad++; $display("FAIL ld_wb_wins: got %h, expected 4", dbg_data); end
    send(32'h01EF5020);
    idle();
    tick(1);
    ld_en = 1'b1; ld_addr = 5'd11; ld_data = 32'h1234;
    tick(1);
    ld_en = 1'b0; m_rf[11] = 32'h1234;
    dbg_addr = 5'd10; #1;
    n_vec++;
    if (dbg_data !== 32'd4) begin n_bad++; $display("FAIL ld_other_wb: got %h, expected 4", dbg_data); end
    dbg_addr = 5'd11; #1;
    n_vec++;
    if (dbg_data !== 32'h1234) begin n_bad++; $display("FAIL ld_other_ld: got %h, expected 1234", dbg_data); end
  endtask

  task automatic test_reset_midstream();
    send(32'h01EFB020);
    send(32'h01EFB820);
    rst_n = 1'b0;
    sb.delete();
    idle();
    dbg_addr = 5'd15; #1;
    n_vec++;
    if ({wb_valid, wb_addr, wb_data, zf, ovf, err, dbg_data} !== 72'd0) begin
      n_bad++; $display("FAIL midrst_outputs: got %h, expected 0", {wb_valid, wb_addr, wb_data, zf, ovf, err, dbg_data});
    end
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_zf = 1'b0; m_ovf = 1'b0;
    tick(3);
    dbg_addr = 5'd22; #1;
    n_vec++;
    if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL midrst_r22: got %h, expected 0", dbg_data); end
    dbg_addr = 5'd23; #1;
    n_vec++;
    if (dbg_data !== 32'd0) begin n_bad++; $display("FAIL midrst_r23: got %h, expected 0", dbg_data); end
  endtask

  task automatic test_no_fwd();
    int  stalls;
    bit  acc;
    nf_ld_en = 1'b1; nf_ld_addr = 5'd15; nf_ld_data = 32'd5; tick(1);
    nf_ld_addr = 5'd9; nf_ld_data = 32'd3; tick(1);
    nf_ld_en = 1'b0;
    nf_if.instr_valid = 1'b1; nf_if.instr = 32'h01E9A022;
    tick(1);
    nf_if.instr = 32'h0289A022; #1;
    n_vec++;
    if (nf_if.instr_ready !== 1'b0) begin n_bad++; $display("FAIL nf_hazard_ready: got %b, expected 0", nf_if.instr_ready); end
    stalls = 0; acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      if (nf_if.instr_ready === 1'b1) acc = 1'b1;
      else stalls++;
      tick(1); #1;
    end
    nf_if.instr_valid = 1'b0;
    n_vec++;
    if (!acc || stalls != 2) begin n_bad++; $display("FAIL nf_stall: got accepted %b stalls %0d, expected 1 2", acc, stalls); end
    tick(3);
    nf_dbg_addr = 5'd20; #1;
    n_vec++;
    if (nf_dbg_data !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL nf_result: got %h, expected ffffffff", nf_dbg_data); end
  endtask

  initial begin
    in_if.instr_valid = 1'b0; in_if.instr = 32'h0;
    nf_if.instr_valid = 1'b0; nf_if.instr = 32'h0;
    ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0; dbg_addr = 5'd0;
    nf_ld_en = 1'b0; nf_ld_addr = 5'd0; nf_ld_data = 32'd0; nf_dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_zf = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_sub_basic();
    test_back_to_back();
    test_overflow();
    test_slt_r0();
    test_nop_err();
    test_ld_collide();
    test_reset_midstream();
    test_no_fwd();
    tick(3);
    n_vec++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending writes, expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
